ex_mem_stage: RTL

//   EX->MEM pipeline register of the MIPS core; captures the ALU result/zero flag plus the store data,

---
 rtl/ex_mem_stage.sv | 82 ++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with beq resolution, single-pulse pc_src and forwarding info.
module ex_mem_stage #(
   parameter int WIDTH      = 32,
   parameter int RA_W       = 5,
   parameter bit SQUASH_TKN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic             ex_valid,
   input  logic [WIDTH-1:0] ex_alu_result,
   input  logic             ex_alu_zero,
   input  logic [WIDTH-1:0] ex_rt_data,
   input  logic [RA_W-1:0]  ex_write_reg,
   input  logic [WIDTH-1:0] ex_branch_target,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic             ex_mem_write,
   input  logic             ex_mem_to_reg,
   input  logic             ex_branch,
   output logic             mem_valid,
   output logic [WIDTH-1:0] mem_alu_result,
   output logic [WIDTH-1:0] mem_write_data,
   output logic [RA_W-1:0]  mem_write_reg,
   output logic             mem_reg_write,
   output logic             mem_mem_read,
   output logic             mem_mem_write,
   output logic             mem_mem_to_reg,
   output logic             pc_src,
   output logic [WIDTH-1:0] mem_branch_target,
   output logic             fwd_en,
   output logic [RA_W-1:0]  fwd_reg,
   output logic [WIDTH-1:0] fwd_data
);
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] alu;
      logic             zero;
      logic [WIDTH-1:0] rt;
      logic [RA_W-1:0]  wr;
      logic [WIDTH-1:0] tgt;
      logic             rw;
      logic             mr;
      logic             mw;
      logic             m2r;
      logic             br;
   } st_t;
   st_t  st_q, st_d, ld;
   logic td_q, td_d, squash;
   assign ld = st_t'({ex_valid, ex_alu_result, ex_alu_zero, ex_rt_data, ex_write_reg, ex_branch_target,
                      ex_reg_write & ex_valid, ex_mem_read & ex_valid, ex_mem_write & ex_valid,
                      ex_mem_to_reg & ex_valid, ex_branch & ex_valid});
   assign pc_src = st_q.valid & st_q.br & st_q.zero & ~td_q;
   assign squash = SQUASH_TKN & pc_src & ~stall;
   // taken_done remembers a pulse already issued while a taken branch sits stalled
   always_comb begin
      st_d = (flush || squash) ? '0 : stall ? st_q : ld;
      td_d = (!flush && stall) ? (td_q | pc_src) : 1'b0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q <= '0;
         td_q <= 1'b0;
      end else begin
         st_q <= st_d;
         td_q <= td_d;
      end
   end
   assign mem_valid         = st_q.valid;
   assign mem_alu_result    = st_q.alu;
   assign mem_write_data    = st_q.rt;
   assign mem_write_reg     = st_q.wr;
   assign mem_reg_write     = st_q.rw & st_q.valid;
   assign mem_mem_read      = st_q.mr & st_q.valid;
   assign mem_mem_write     = st_q.mw & st_q.valid;
   assign mem_mem_to_reg    = st_q.m2r & st_q.valid;
   assign mem_branch_target = st_q.tgt;
   assign fwd_en            = mem_reg_write & ~mem_mem_read & (st_q.wr != '0);
   assign fwd_reg           = st_q.wr;
   assign fwd_data          = st_q.alu;
endmodule
